// File: rtl/pedal_pkg.sv
// Shared types for the frame readout path: default sample width, sample type and readout FSM states.
package pedal_pkg;

   localparam int DEFAULT_DATA_W = 16;

   typedef logic signed [DEFAULT_DATA_W-1:0] sample_t;

   typedef enum logic {
      WAIT_FIRST = 1'b0,
      RUN        = 1'b1
   } readout_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sample_fifo
   import pedal_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              push,
   input  logic [DATA_W-1:0]                 push_data,
   input  logic                              pop,
   output logic [DATA_W-1:0]                 pop_data,
   output logic                              full,
   output logic                              empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;
   logic              push_ok;
   logic              pop_ok;

   assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
   assign empty    = (count_reg == '0);
   assign count    = count_reg;
   assign pop_ok   = pop & ~empty;
   assign push_ok  = push & (~full | pop_ok);
   assign pop_data = mem[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop_ok})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   // Storage carries no reset so it can map onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/frame_readout.sv
// Captures the accumulator sum at each adc_clock rising edge, scales it by 2^-SHIFT and queues it for output.
// Optional macro FRAME_READOUT_ROUND_EN selects round-half-up instead of truncation before the shift.
module frame_readout
   import pedal_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int SHIFT      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              adc_clock,
   input  logic [DATA_W-1:0] acc_in,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LEN_W-1:0]  frame_len,
   output logic              overflow
);

   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   logic signed [DATA_W-1:0] acc_q;
   logic                     adc_q;
   logic [LEN_W-1:0]         low_cnt_reg;
   logic [LEN_W-1:0]         frame_len_reg;
   logic [LEN_W-1:0]         frame_len_next;
   readout_state_t           state_reg;
   readout_state_t           state_next;
   logic                     overflow_reg;
   logic                     frame_edge;
   logic                     push_req;
   logic                     pop_req;
   logic                     drop;
   logic [DATA_W-1:0]        scaled;
   logic [DATA_W-1:0]        fifo_head;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [CNT_W-1:0]         fifo_count;

   // acc_q still holds the finished sum in the cycle adc_clock first reads high.
   assign frame_edge = adc_clock & ~adc_q;

`ifdef FRAME_READOUT_ROUND_EN
   localparam logic signed [DATA_W:0] HALF_LSB = (DATA_W+1)'(1) << (SHIFT-1);
   logic signed [DATA_W:0] rounded;

   // One guard bit keeps the most positive sum from wrapping negative after the rounding add.
   assign rounded = $signed({acc_q[DATA_W-1], acc_q}) + HALF_LSB;
   assign scaled  = DATA_W'(rounded >>> SHIFT);
`else
   assign scaled  = DATA_W'(acc_q >>> SHIFT);
`endif

   always_comb begin
      state_next     = state_reg;
      frame_len_next = frame_len_reg;
      push_req       = 1'b0;
      if (frame_edge) begin
         case (state_reg)
            WAIT_FIRST: state_next = RUN;
            RUN: begin
               frame_len_next = low_cnt_reg;
               push_req       = (low_cnt_reg != '0);
            end
            default: state_next = WAIT_FIRST;
         endcase
      end
   end

   assign pop_req = out_ready & ~fifo_empty;
   assign drop    = push_req & fifo_full & ~pop_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q         <= '0;
         adc_q         <= 1'b0;
         low_cnt_reg   <= '0;
         frame_len_reg <= '0;
         state_reg     <= WAIT_FIRST;
         overflow_reg  <= 1'b0;
      end else begin
         acc_q         <= $signed(acc_in);
         adc_q         <= adc_clock;
         frame_len_reg <= frame_len_next;
         state_reg     <= state_next;
         if (frame_edge) begin
            low_cnt_reg <= '0;
         end else if (!adc_clock && (low_cnt_reg != '1)) begin
            low_cnt_reg <= low_cnt_reg + LEN_W'(1);
         end
         if (drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   sample_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_req),
      .push_data (scaled),
      .pop       (pop_req),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign out_valid = ~fifo_empty;
   assign out_data  = (fifo_count != '0) ? fifo_head : '0;
   assign frame_len = frame_len_reg;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_frame_readout.sv
// Scoreboard bench for frame_readout: expected samples are queued as frames are driven and compared on pop.
module tb_frame_readout;

   localparam int DATA_W = 16;
   localparam int LEN_W  = 8;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              adc_clock;
   logic [DATA_W-1:0] acc_in;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [LEN_W-1:0]  frame_len;
   logic              overflow;

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   bit base_ready = 1'b0;

   logic [DATA_W-1:0] exp_q[$];
   int                m_cnt;
   bit                m_adc;
   bit                m_run;
   bit                m_ovf;
   logic [LEN_W-1:0]  m_flen;
   logic [DATA_W-1:0] m_acc;

   always #5 clk = ~clk;

   frame_readout #(
      .DATA_W     (DATA_W),
      .SHIFT      (4),
      .FIFO_DEPTH (DEPTH),
      .LEN_W      (LEN_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .adc_clock (adc_clock),
      .acc_in    (acc_in),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_len (frame_len),
      .overflow  (overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Floor division by 16, with +8 first when rounding is enabled.
   function automatic logic [DATA_W-1:0] model_scale(input logic [DATA_W-1:0] raw);
      int v;
      int q;
      v = $signed(raw);
`ifdef FRAME_READOUT_ROUND_EN
      v = v + 8;
`endif
      if (v >= 0) q = v / 16;
      else        q = -((-v + 15) / 16);
      return q[DATA_W-1:0];
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_cnt  = 0;
      m_adc  = 1'b0;
      m_run  = 1'b0;
      m_ovf  = 1'b0;
      m_flen = '0;
      m_acc  = '0;
   endtask

   // Called at a negedge with inputs already driven: check outputs, advance the model, run one clock.
   task automatic step();
      bit edge_now;
      bit pop_now;
      bit full_before;
      check("valid", out_valid, exp_q.size() != 0);
      check("overflow", overflow, m_ovf);
      check("frame_len", frame_len, m_flen);
      pop_now = out_ready && (exp_q.size() != 0);
      if (pop_now) begin
         check("data", out_data, exp_q[0]);
         $display("pop data=%h expected=%h", out_data, exp_q[0]);
         pops++;
      end
      if (rst) begin
         model_reset();
      end else begin
         edge_now    = adc_clock && !m_adc;
         full_before = (exp_q.size() == DEPTH);
         if (pop_now) void'(exp_q.pop_front());
         if (edge_now && m_run) begin
            m_flen = m_cnt[LEN_W-1:0];
            if (m_cnt != 0) begin
               if (full_before && !pop_now) m_ovf = 1'b1;
               else exp_q.push_back(model_scale(m_acc));
            end
         end
         if (edge_now) m_run = 1'b1;
         if (edge_now) m_cnt = 0;
         else if (!adc_clock && m_cnt < 255) m_cnt++;
         m_adc = adc_clock;
         m_acc = acc_in;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic frame(input int low, input logic [DATA_W-1:0] sum, input int high, input bit rdy_edge);
      for (int i = 0; i < low; i++) begin
         adc_clock = 1'b0;
         acc_in    = (i == low - 1) ? sum : DATA_W'($urandom);
         step();
      end
      for (int i = 0; i < high; i++) begin
         adc_clock = 1'b1;
         acc_in    = '0;
         out_ready = (i == 0 && rdy_edge) ? 1'b1 : base_ready;
         step();
         out_ready = base_ready;
      end
   endtask

   task automatic drain();
      adc_clock = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      check("drain_done", exp_q.size(), 0);
      out_ready = base_ready;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      adc_clock = 1'b0;
      acc_in    = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      rst = 1'b0;
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_len", frame_len, 0);
      check("rst_ovf", overflow, 0);

      // first edge after reset only arms the FSM
      frame(5, 16'h0100, 3, 1'b0);
      check("t1_valid", out_valid, 0);

      frame(10, 16'h0100, 3, 1'b0);
      check("t2_valid", out_valid, 1);
      check("t2_data", out_data, 16'h0010);
      check("t2_len", frame_len, 10);
      drain();

      frame(6, 16'hFFF8, 2, 1'b0);
`ifdef FRAME_READOUT_ROUND_EN
      check("t3_neg", out_data, 16'h0000);
`else
      check("t3_neg", out_data, 16'hFFFF);
`endif
      drain();
      frame(6, 16'h7FFF, 2, 1'b0);
`ifdef FRAME_READOUT_ROUND_EN
      check("t3_max", out_data, 16'h0800);
`else
      check("t3_max", out_data, 16'h07FF);
`endif
      drain();

      // full FIFO with a pop in the edge cycle: nothing dropped
      pops = 0;
      for (int f = 0; f < DEPTH; f++) frame(4, 16'(16'h0200 + 16 * f), 2, 1'b0);
      check("t5_full_valid", out_valid, 1);
      frame(4, 16'h0A00, 2, 1'b1);
      check("t5_ovf", overflow, 0);
      drain();
      check("t5_pops", pops, DEPTH + 1);

      // five frames without draining: fifth dropped
      pops = 0;
      for (int f = 1; f <= 5; f++) frame(3, 16'(16 * f), 2, 1'b0);
      check("t4_ovf", overflow, 1);
      drain();
      check("t4_pops", pops, DEPTH);

      // reset mid-frame with two entries queued
      frame(4, 16'h0110, 2, 1'b0);
      frame(4, 16'h0120, 2, 1'b0);
      check("t6_pre_valid", out_valid, 1);
      adc_clock = 1'b0;
      step();
      step();
      pulse_reset();
      check("t6_valid", out_valid, 0);
      check("t6_ovf", overflow, 0);
      frame(4, 16'h0200, 2, 1'b0);
      check("t6_wait_first", out_valid, 0);
      frame(4, 16'h0300, 2, 1'b0);
      check("t6_run_valid", out_valid, 1);
      check("t6_run_data", out_data, 16'h0030);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
